// File: rtl/pcileech_tlp_pkt_fifo.sv
// Store-and-forward TLP packet buffer: beats become readable only once their
// packet is complete; overflowing or over-long packets are dropped whole.
module pcileech_tlp_pkt_fifo #(
  parameter int DATA_W        = 32,
  parameter int DEPTH         = 512,
  parameter int MAX_PKT_WORDS = 132
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [DATA_W-1:0]          in_data,
  input  logic                       in_last,
  input  logic                       in_valid,
  input  logic                       in_flush,
  output logic [DATA_W-1:0]          out_data,
  output logic                       out_last,
  output logic                       out_valid,
  output logic                       out_empty,
  input  logic                       out_rd_en,
  output logic [$clog2(DEPTH):0]     out_pkt_cnt,
  output logic [$clog2(DEPTH):0]     out_free,
  output logic [15:0]                drop_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam int LW = $clog2(MAX_PKT_WORDS + 1);

  typedef enum logic {ACCEPT, DISCARD} state_e;

  state_e            state_q, state_d;
  logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]     wr_commit_q, wr_commit_d;
  logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]     pkt_cnt_q, pkt_cnt_d;
  logic [LW-1:0]     pkt_len_q, pkt_len_d;
  logic [15:0]       drop_q, drop_d;
  logic              out_valid_q;
  logic [DATA_W-1:0] out_data_q;
  logic              out_last_q;
  logic [PW-1:0]     out_free_q;

  logic [DATA_W:0]   mem [DEPTH];
  logic [DATA_W:0]   rd_word;
  logic [PW-1:0]     used;
  logic              full;
  logic              we;
  logic              commit;
  logic              rd_issue;

  // Occupancy counts speculative beats, so a partial packet reserves space.
  assign used      = wr_ptr_q - rd_ptr_q;
  assign full      = (used == PW'(DEPTH));
  assign rd_word   = mem[rd_ptr_q[AW-1:0]];
  assign out_empty = (pkt_cnt_q == '0);

  always_comb begin
    state_d     = state_q;
    wr_ptr_d    = wr_ptr_q;
    wr_commit_d = wr_commit_q;
    rd_ptr_d    = rd_ptr_q;
    pkt_len_d   = pkt_len_q;
    pkt_cnt_d   = pkt_cnt_q;
    drop_d      = drop_q;
    we          = 1'b0;
    commit      = 1'b0;
    rd_issue    = 1'b0;
    if (in_flush) begin
      state_d     = ACCEPT;
      wr_ptr_d    = '0;
      wr_commit_d = '0;
      rd_ptr_d    = '0;
      pkt_len_d   = '0;
      pkt_cnt_d   = '0;
    end else begin
      case (state_q)
        ACCEPT: begin
          if (in_valid) begin
            if (full || (pkt_len_q == LW'(MAX_PKT_WORDS))) begin
              // Roll back to the last packet boundary and skip the rest.
              wr_ptr_d  = wr_commit_q;
              pkt_len_d = '0;
              if (drop_q != 16'hFFFF) drop_d = drop_q + 16'd1;
              if (!in_last) state_d = DISCARD;
            end else begin
              we        = 1'b1;
              wr_ptr_d  = wr_ptr_q + PW'(1);
              pkt_len_d = pkt_len_q + LW'(1);
              if (in_last) begin
                wr_commit_d = wr_ptr_q + PW'(1);
                pkt_len_d   = '0;
                commit      = 1'b1;
              end
            end
          end
        end
        DISCARD: begin
          if (in_valid && in_last) state_d = ACCEPT;
        end
        default: state_d = ACCEPT;
      endcase
      rd_issue = out_rd_en && !out_empty;
      if (rd_issue) rd_ptr_d = rd_ptr_q + PW'(1);
      pkt_cnt_d = pkt_cnt_q + PW'(commit) - PW'(rd_issue && rd_word[DATA_W]);
    end
  end

  always_ff @(posedge clk) begin
    if (we) mem[wr_ptr_q[AW-1:0]] <= {in_last, in_data};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ACCEPT;
      wr_ptr_q    <= '0;
      wr_commit_q <= '0;
      rd_ptr_q    <= '0;
      pkt_len_q   <= '0;
      pkt_cnt_q   <= '0;
      drop_q      <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
      out_free_q  <= PW'(DEPTH);
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      wr_commit_q <= wr_commit_d;
      rd_ptr_q    <= rd_ptr_d;
      pkt_len_q   <= pkt_len_d;
      pkt_cnt_q   <= pkt_cnt_d;
      drop_q      <= drop_d;
      out_valid_q <= rd_issue;
      out_free_q  <= PW'(DEPTH) - used;
      if (rd_issue) begin
        out_data_q <= rd_word[DATA_W-1:0];
        out_last_q <= rd_word[DATA_W];
      end
    end
  end

  assign out_data    = out_data_q;
  assign out_last    = out_last_q;
  assign out_valid   = out_valid_q;
  assign out_pkt_cnt = pkt_cnt_q;
  assign out_free    = out_free_q;
  assign drop_cnt    = drop_q;

endmodule

// File: tb/tb_pcileech_tlp_pkt_fifo.sv
// Scoreboard bench for pcileech_tlp_pkt_fifo: a queue-based packet model
// predicts read data and counters; a monitor checks every output beat.
module tb_pcileech_tlp_pkt_fifo;
  localparam int DW    = 32;
  localparam int DEPTH = 8;
  localparam int MAXW  = 6;
  localparam int PW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic          in_last = 1'b0, in_valid = 1'b0, in_flush = 1'b0;
  logic [DW-1:0] out_data;
  logic          out_last, out_valid, out_empty;
  logic          out_rd_en = 1'b0;
  logic [PW-1:0] out_pkt_cnt, out_free;
  logic [15:0]   drop_cnt;

  pcileech_tlp_pkt_fifo #(.DATA_W(DW), .DEPTH(DEPTH), .MAX_PKT_WORDS(MAXW)) dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_last(in_last),
    .in_valid(in_valid), .in_flush(in_flush), .out_data(out_data),
    .out_last(out_last), .out_valid(out_valid), .out_empty(out_empty),
    .out_rd_en(out_rd_en), .out_pkt_cnt(out_pkt_cnt), .out_free(out_free),
    .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: committed-but-unread beats, current partial packet.
  logic [DW:0] stq[$];
  logic [DW:0] partq[$];
  logic [DW:0] expq[$];
  int          mpk = 0;
  int          mdrop = 0;
  bit          mdisc = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic model_reset();
    stq.delete(); partq.delete(); expq.delete();
    mpk = 0; mdrop = 0; mdisc = 0;
  endtask

  // One clock of stimulus; model advances by the same edge.
  task automatic step(input bit v, input bit l, input logic [DW-1:0] d,
                      input bit r, input bit f);
    bit rd_ok;
    logic [DW:0] b;
    @(negedge clk); #1;
    in_valid = v; in_last = l; in_data = d; out_rd_en = r; in_flush = f;
    if (f) begin
      stq.delete(); partq.delete(); mpk = 0; mdisc = 0;
    end else begin
      rd_ok = r && (mpk > 0);
      if (v) begin
        if (mdisc) begin
          if (l) mdisc = 0;
        end else if ((stq.size() + partq.size() == DEPTH) || (partq.size() == MAXW)) begin
          partq.delete();
          if (mdrop < 65535) mdrop++;
          if (!l) mdisc = 1;
        end else begin
          partq.push_back({l, d});
          if (l) begin
            for (int i = 0; i < partq.size(); i++) stq.push_back(partq[i]);
            partq.delete();
            mpk++;
          end
        end
      end
      if (rd_ok) begin
        b = stq.pop_front();
        expq.push_back(b);
        if (b[DW]) mpk--;
      end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, '0, 0, 0);
  endtask

  task automatic settle_check(input string tag);
    idle(2);
    @(posedge clk); #1;
    chk({tag, "_pkt_cnt"}, int'(out_pkt_cnt), mpk);
    chk({tag, "_empty"}, int'(out_empty), int'(mpk == 0));
    chk({tag, "_drop"}, int'(drop_cnt), mdrop);
    chk({tag, "_free"}, int'(out_free), DEPTH - (stq.size() + partq.size()));
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 4 * DEPTH && mpk > 0; i++) step(0, 0, '0, 1, 0);
    settle_check(tag);
    chk({tag, "_pending"}, expq.size(), 0);
  endtask

  task automatic send_pkt(input int len, input logic [DW-1:0] base, input bit with_last);
    for (int i = 0; i < len; i++)
      step(1, with_last && (i == len - 1), base + DW'(i), 0, 0);
  endtask

  // Monitor: exactly one expected beat per cycle following an issued read.
  always @(negedge clk) begin
    logic [DW:0] e;
    if (rst_n && (out_valid || expq.size() > 0)) begin
      if (expq.size() == 0) begin
        n_tests++; n_fail++;
        $display("FAIL unexpected_beat: got out_valid=1 data 0x%0h expected no beat", out_data);
      end else begin
        e = expq.pop_front();
        chk("beat_valid", int'(out_valid), 1);
        if (out_valid) begin
          chk("beat_data", int'(out_data), int'(e[DW-1:0]));
          chk("beat_last", int'(out_last), int'(e[DW]));
        end
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected $finish");
    $fatal(1);
  end

  initial begin
    int rem;
    bit v, l, r, f;
    model_reset();
    #12;
    chk("rst_valid", int'(out_valid), 0);
    chk("rst_data", int'(out_data), 0);
    chk("rst_last", int'(out_last), 0);
    chk("rst_empty", int'(out_empty), 1);
    chk("rst_free", int'(out_free), DEPTH);
    chk("rst_drop", int'(drop_cnt), 0);
    chk("rst_pkt_cnt", int'(out_pkt_cnt), 0);
    @(negedge clk); rst_n = 1'b1;

    // Single 4-beat packet: visible only after the last beat.
    for (int k = 0; k < 4; k++) begin
      step(1, k == 3, DW'(32'h11 + k), 0, 0);
      @(posedge clk); #1;
      chk("t1_empty", int'(out_empty), int'(k != 3));
    end
    chk("t1_pkt_cnt", int'(out_pkt_cnt), 1);
    for (int k = 0; k < 4; k++) step(0, 0, '0, 1, 0);
    @(posedge clk); #1;
    chk("t1_empty_after", int'(out_empty), 1);
    drain("t1");

    // Flush discards a partial packet without counting a drop.
    send_pkt(3, 32'h100, 0);
    step(0, 0, '0, 0, 1);
    send_pkt(2, 32'h200, 1);
    settle_check("t5");
    chk("t5_pkt_cnt_abs", int'(out_pkt_cnt), 1);
    chk("t5_drop_abs", int'(drop_cnt), 0);
    drain("t5");

    // Overflow: second packet hits full storage at its 3rd beat.
    send_pkt(6, 32'h300, 1);
    send_pkt(4, 32'h400, 1);
    settle_check("t2");
    chk("t2_drop_abs", int'(drop_cnt), 1);
    chk("t2_pkt_cnt_abs", int'(out_pkt_cnt), 1);
    chk("t2_free_abs", int'(out_free), 2);
    drain("t2");

    // Over-length packet dropped, short one after it kept.
    send_pkt(8, 32'h500, 1);
    send_pkt(2, 32'h600, 1);
    settle_check("t3");
    chk("t3_drop_abs", int'(drop_cnt), 2);
    chk("t3_pkt_cnt_abs", int'(out_pkt_cnt), 1);
    chk("t3_free_abs", int'(out_free), DEPTH - 2);
    drain("t3");

    // Commit of B in the same cycle as the last read of A.
    send_pkt(2, 32'h700, 1);
    settle_check("t4a");
    step(1, 0, 32'h800, 1, 0);
    step(1, 1, 32'h801, 1, 0);
    @(posedge clk); #1;
    chk("t4_pkt_cnt", int'(out_pkt_cnt), 1);
    drain("t4");

    // Randomised traffic.
    rem = 0;
    for (int c = 0; c < 3000; c++) begin
      v = ($urandom_range(3) != 0);
      l = 0;
      if (v) begin
        if (rem == 0) rem = $urandom_range(8, 1);
        l = (rem == 1);
        rem--;
      end
      r = $urandom_range(1);
      f = ($urandom_range(199) == 0);
      if (f) rem = 0;
      step(v, l, DW'($urandom), r, f);
      if (c % 500 == 499) settle_check("rnd");
    end
    while (rem > 0) begin
      step(1, rem == 1, DW'($urandom), 0, 0);
      rem--;
    end
    drain("rnd_end");

    // Asynchronous reset while a beat is being presented.
    send_pkt(2, 32'h900, 1);
    send_pkt(3, 32'hA00, 1);
    settle_check("t6pre");
    step(0, 0, '0, 1, 0);
    @(posedge clk); #2;
    chk("t6_valid_before", int'(out_valid), 1);
    rst_n = 1'b0;
    #1;
    model_reset();
    chk("t6_valid", int'(out_valid), 0);
    chk("t6_empty", int'(out_empty), 1);
    chk("t6_free", int'(out_free), DEPTH);
    chk("t6_drop", int'(drop_cnt), 0);
    chk("t6_pkt_cnt", int'(out_pkt_cnt), 0);
    @(negedge clk);
    out_rd_en = 1'b0;
    rst_n = 1'b1;
    send_pkt(2, 32'hB00, 1);
    drain("t6post");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
